// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational ROM and keeps one
// registered fetch entry toward decode, with redirect/flush, halt/resume and a delivery counter.
module ifetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_a,
   input  logic [31:0] rom_inst,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        if_valid,
   input  logic        id_ready,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        halt_req,
   input  logic        go,
   output logic        halted,
   output logic        misalign,
   output logic [31:0] fetch_cnt
);

   typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] cnt_q, cnt_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;
   logic        xfer, load;

   assign xfer = valid_q && id_ready;
   assign load = (state_q == S_FETCH) && (!valid_q || id_ready) && !br_taken;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      mis_d   = 1'b0;
      cnt_d   = cnt_q + {31'd0, xfer};

      // A redirect flushes the stage even when a transfer happens; that transfer still counts.
      if (br_taken) begin
         pc_d    = br_target & ~32'h3;
         valid_d = 1'b0;
         mis_d   = |br_target[1:0];
      end else if (load) begin
         inst_d  = rom_inst;
         ipc_d   = pc_q;
         valid_d = 1'b1;
         pc_d    = pc_q + PC_STEP;
      end else if (xfer) begin
         valid_d = 1'b0;
      end

      case (state_q)
         S_FETCH: if (halt_req) state_d = S_HALT;
         S_HALT:  if (go && !halt_req) state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
         ipc_q   <= 32'd0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rom_a     = pc_q;
   assign if_inst   = inst_q;
   assign if_pc     = ipc_q;
   assign if_valid  = valid_q;
   assign halted    = (state_q == S_HALT);
   assign misalign  = mis_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: a reference model queues each fetched word in issue
// order; a negedge monitor pops and compares on every decode handshake.
module tb_ifetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, id_ready, br_taken, halt_req, go;
   logic [31:0] br_target, rom_a, rom_inst, if_inst, if_pc, fetch_cnt;
   logic        if_valid, halted, misalign;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;
   ent_t exp_q[$];

   logic [31:0] m_pc, m_cnt;
   bit          m_valid, m_halt, m_mis;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'hA000_0000 | {26'd0, a[7:2]};
   endfunction

   assign rom_inst = rom_word(rom_a);

   ifetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
      .clk(clk), .rst(rst), .rom_a(rom_a), .rom_inst(rom_inst),
      .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid), .id_ready(id_ready),
      .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req), .go(go),
      .halted(halted), .misalign(misalign), .fetch_cnt(fetch_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the fetch stage is a 0/1-entry queue of issued words.
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'h0; m_cnt = 0; m_valid = 0; m_halt = 0; m_mis = 0;
         exp_q.delete();
      end else begin
         if (m_valid && id_ready) m_cnt = m_cnt + 1;
         if (br_taken) begin
            if (m_valid && !id_ready && exp_q.size() > 0) void'(exp_q.pop_back());
            m_valid = 0;
            m_pc    = {br_target[31:2], 2'b00};
            m_mis   = (br_target[1:0] != 2'b00);
         end else begin
            m_mis = 0;
            if (!m_halt && (!m_valid || id_ready)) begin
               exp_q.push_back('{pc: m_pc, inst: rom_word(m_pc)});
               m_valid = 1;
               m_pc    = m_pc + 32'd4;
            end else if (m_valid && id_ready) begin
               m_valid = 0;
            end
         end
         if (!m_halt && halt_req) m_halt = 1;
         else if (m_halt && go && !halt_req) m_halt = 0;
      end
   end

   always @(negedge clk) begin
      ent_t e;
      if (!rst) begin
         chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
         chk("fetch_cnt", fetch_cnt, m_cnt);
         chk("halted", {31'd0, halted}, {31'd0, m_halt});
         chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
         chk("rom_a", rom_a, m_pc);
         if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL handshake: got if_pc %h with no expected entry", if_pc);
            end else begin
               e = exp_q.pop_front();
               chk("if_pc", if_pc, e.pc);
               chk("if_inst", if_inst, e.inst);
            end
         end
      end
   end

   initial begin
      rst = 1; id_ready = 0; br_taken = 0; br_target = 0; halt_req = 0; go = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0; id_ready = 1;
      @(negedge clk);
      chk("reset if_inst", if_inst, 32'h0);
      chk("reset if_pc", if_pc, 32'h0);
      chk("reset if_valid", {31'd0, if_valid}, 32'd0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("burst fetch_cnt", fetch_cnt, 32'd8);
      chk("burst if_pc", if_pc, 32'h20);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst      = ($urandom_range(0, 199) == 0);
         id_ready = ($urandom_range(0, 9) < 7);
         br_taken = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       br_target = $urandom;
            1:       br_target = {24'hFF_FFFF, 8'($urandom)};
            default: br_target = {24'd0, 8'($urandom)};
         endcase
         halt_req = ($urandom_range(0, 19) == 0);
         go       = ($urandom_range(0, 3) == 0);
         if (rst) begin
            @(negedge clk);
            @(negedge clk);
            chk("mid reset if_inst", if_inst, 32'h0);
            chk("mid reset if_pc", if_pc, 32'h0);
            chk("mid reset fetch_cnt", fetch_cnt, 32'h0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
